// File: rtl/bnn_mlp_core.sv
// Two-layer binary MLP core: XNOR-popcount neurons with threshold activation, an argmax class
// output, a two-stage valid pipeline and a drained, handshaked weight reload port.
module bnn_mlp_core #(
  parameter int IN_W  = 8,
  parameter int HID_N = 8,
  parameter int OUT_N = 4,
  parameter int LD_W  = 4,
  parameter int TH1   = IN_W / 2,
  parameter int TH2   = HID_N / 2,
  localparam int CW   = (OUT_N > 1) ? $clog2(OUT_N) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [LD_W-1:0]   load_data,
  output logic              load_ready,
  output logic              cfg_loaded,
  input  logic              in_valid,
  input  logic [IN_W-1:0]   in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [OUT_N-1:0]  out_data,
  output logic [CW-1:0]     out_class
);

  localparam int HB     = HID_N * IN_W;
  localparam int NB     = HB + OUT_N * HID_N;
  localparam int NBEATS = NB / LD_W;
  localparam int PW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int P1W    = $clog2(IN_W + 1);
  localparam int P2W    = $clog2(HID_N + 1);
  localparam logic [P1W-1:0] TH1_V = P1W'(TH1);
  localparam logic [P2W-1:0] TH2_V = P2W'(TH2);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_LOAD} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [NB-1:0]      r_w;
  logic [PW-1:0]      r_ptr;
  logic               r_cfg;
  logic               r_v1;
  logic [HID_N-1:0]   r_hid;
  logic               r_out_valid;
  logic [OUT_N-1:0]   r_out_data;
  logic [CW-1:0]      r_out_class;

  logic               w_beat;
  logic               w_last;
  logic [P1W-1:0]     w_pop1 [HID_N];
  logic [HID_N-1:0]   w_hid;
  logic [P2W-1:0]     w_pop2 [OUT_N];
  logic [P2W-1:0]     w_best;
  logic [OUT_N-1:0]   w_act;
  logic [CW-1:0]      w_cls;

  assign w_beat     = load_valid && load_ready;
  assign w_last     = (r_ptr == PW'(NBEATS - 1));
  assign cfg_loaded = r_cfg;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_class  = r_out_class;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_RUN;
    else        r_state <= w_state_nxt;
  end

  // Reload waits in DRAIN until both pipeline stages are empty so no sample sees mixed weights.
  always_comb begin
    w_state_nxt = r_state;
    if (ena) begin
      case (r_state)
        S_RUN:   if (load_start) w_state_nxt = S_DRAIN;
        S_DRAIN: if (!r_v1 && !r_out_valid) w_state_nxt = S_LOAD;
        S_LOAD:  if (w_beat && w_last) w_state_nxt = S_RUN;
        default: w_state_nxt = S_RUN;
      endcase
    end
  end

  always_comb begin
    in_ready   = 1'b0;
    load_ready = 1'b0;
    case (r_state)
      S_RUN:   in_ready   = ena;
      S_LOAD:  load_ready = ena;
      default: ;
    endcase
  end

  always_comb begin
    w_hid = '0;
    for (int h = 0; h < HID_N; h++) begin
      w_pop1[h] = '0;
      for (int i = 0; i < IN_W; i++)
        w_pop1[h] = w_pop1[h] + P1W'(in_data[i] ~^ r_w[h*IN_W + i]);
      w_hid[h] = (w_pop1[h] >= TH1_V);
    end
  end

  always_comb begin
    for (int o = 0; o < OUT_N; o++) begin
      w_pop2[o] = '0;
      for (int j = 0; j < HID_N; j++)
        w_pop2[o] = w_pop2[o] + P2W'(r_hid[j] ~^ r_w[HB + o*HID_N + j]);
    end
  end

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    w_act  = '0;
    w_cls  = '0;
    w_best = '0;
    for (int o = 0; o < OUT_N; o++) begin
      w_act[o] = (w_pop2[o] >= TH2_V);
      if (w_pop2[o] > w_best) begin
        w_best = w_pop2[o];
        w_cls  = CW'(o);
      end
    end
  end

  // Stage 1: hidden activations, data only
  always_ff @(posedge clk) begin
    if (ena && in_valid && in_ready) r_hid <= w_hid;
  end

  // Stage 1 valid, stage 2 result and weight loading
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w         <= '0;
      r_ptr       <= '0;
      r_cfg       <= 1'b0;
      r_v1        <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_class <= '0;
    end else if (ena) begin
      r_v1        <= in_valid && in_ready;
      r_out_valid <= r_v1;
      if (r_v1) begin
        r_out_data  <= w_act;
        r_out_class <= w_cls;
      end
      if (w_beat) begin
        r_w[int'(r_ptr)*LD_W +: LD_W] <= load_data;
        if (w_last) begin
          r_ptr <= '0;
          r_cfg <= 1'b1;
        end else begin
          r_ptr <= r_ptr + PW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bnn_mlp_core.sv
// Bench for bnn_mlp_core: directed scenarios with literal expectations plus a randomized phase,
// all outputs compared every cycle against a behavioural network/handshake model.
module tb_bnn_mlp_core;
  localparam int IN_W = 8, HID_N = 8, OUT_N = 4, LD_W = 4;
  localparam int TH1 = IN_W / 2, TH2 = HID_N / 2;
  localparam int HB = HID_N * IN_W, NB = HB + OUT_N * HID_N, NBEATS = NB / LD_W;

  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1;
  logic load_start = 1'b0, load_valid = 1'b0, in_valid = 1'b0;
  logic [LD_W-1:0] load_data = '0;
  logic [IN_W-1:0] in_data = '0;
  logic load_ready, cfg_loaded, in_ready, out_valid;
  logic [OUT_N-1:0] out_data;
  logic [1:0] out_class;

  int n_tests = 0, n_fail = 0;

  bnn_mlp_core dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .load_start(load_start),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .cfg_loaded(cfg_loaded), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_class(out_class)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int due; logic [OUT_N-1:0] d; logic [1:0] c; } ent_t;
  ent_t q[$];
  logic [NB-1:0] m_w;
  int m_mode, m_beat, n_en;
  logic m_cfg;
  logic [OUT_N-1:0] last_d;
  logic [1:0] last_c;

  task automatic model_eval(input logic [IN_W-1:0] x, output logic [OUT_N-1:0] d, output logic [1:0] c);
    logic [HID_N-1:0] hid;
    int cnt, best;
    best = -1; c = 0; d = '0;
    for (int h = 0; h < HID_N; h++) begin
      cnt = 0;
      for (int i = 0; i < IN_W; i++) if (x[i] == m_w[h*IN_W + i]) cnt++;
      hid[h] = (cnt >= TH1);
    end
    for (int o = 0; o < OUT_N; o++) begin
      cnt = 0;
      for (int j = 0; j < HID_N; j++) if (hid[j] == m_w[HB + o*HID_N + j]) cnt++;
      d[o] = (cnt >= TH2);
      if (cnt > best) begin best = cnt; c = 2'(o); end
    end
  endtask

  always @(negedge clk) begin
    logic e_ov;
    logic [OUT_N-1:0] nd;
    logic [1:0] nc;
    if (!rst_n) begin
      q.delete(); m_w = '0; m_mode = 0; m_beat = 0; n_en = 0;
      m_cfg = 1'b0; last_d = '0; last_c = '0;
    end else begin
      while (q.size() > 0 && q[0].due < n_en) void'(q.pop_front());
      e_ov = (q.size() > 0) && (q[0].due == n_en);
      if (e_ov) begin last_d = q[0].d; last_c = q[0].c; end
      chk("m_out_valid", 32'(out_valid), 32'(e_ov));
      chk("m_out_data", 32'(out_data), 32'(last_d));
      chk("m_out_class", 32'(out_class), 32'(last_c));
      chk("m_cfg_loaded", 32'(cfg_loaded), 32'(m_cfg));
      chk("m_in_ready", 32'(in_ready), 32'(ena && m_mode == 0));
      chk("m_load_ready", 32'(load_ready), 32'(ena && m_mode == 2));
      if (ena) begin
        if (in_valid && m_mode == 0) begin
          model_eval(in_data, nd, nc);
          q.push_back('{due: n_en + 2, d: nd, c: nc});
        end
        case (m_mode)
          0: if (load_start) m_mode = 1;
          1: if (q.size() == 0) m_mode = 2;
          default: if (load_valid) begin
            for (int b = 0; b < LD_W; b++) m_w[m_beat*LD_W + b] = load_data[b];
            m_beat++;
            if (m_beat == NBEATS) begin m_beat = 0; m_cfg = 1'b1; m_mode = 0; end
          end
        endcase
        n_en++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic infer(input string nm, input logic [IN_W-1:0] x,
                       input logic [OUT_N-1:0] ed, input logic [1:0] ec);
    @(posedge clk) #1; in_valid = 1'b1; in_data = x;
    @(posedge clk) #1; in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk({nm, "_valid"}, 32'(out_valid), 32'd1);
    chk({nm, "_data"}, 32'(out_data), 32'(ed));
    chk({nm, "_class"}, 32'(out_class), 32'(ec));
  endtask

  task automatic load_cfg(input logic [NB-1:0] bits, input int nb, input bit do_start);
    int k, g;
    logic acc;
    @(posedge clk) #1;
    if (do_start) begin load_start = 1'b1; @(posedge clk) #1; load_start = 1'b0; end
    k = 0; g = 0;
    load_valid = 1'b1; load_data = bits[LD_W-1:0];
    while (k < nb && g < 300) begin
      @(negedge clk); acc = load_ready;
      @(posedge clk) #1; g++;
      if (acc) begin
        k++;
        if (k < nb) load_data = bits[k*LD_W +: LD_W];
      end
    end
    load_valid = 1'b0;
    if (k < nb) begin
      n_tests++; n_fail++;
      $display("FAIL load_timeout: got %0d beats, expected %0d", k, nb);
    end
  endtask

  task automatic do_reset();
    @(posedge clk) #1;
    rst_n = 1'b0; load_valid = 1'b0; load_start = 1'b0; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  initial begin
    logic [NB-1:0] bits;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_cfg", 32'(cfg_loaded), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Reset weights
    infer("zw_x00", 8'h00, 4'h0, 2'd0);
    infer("zw_xFF", 8'hFF, 4'hF, 2'd0);

    // All-ones weights, threshold edge
    bits = '1;
    load_cfg(bits, NBEATS, 1'b1);
    @(negedge clk);
    chk("ones_cfg", 32'(cfg_loaded), 32'd1);
    infer("ones_x0F", 8'h0F, 4'hF, 2'd0);

    // Single winner, then a tie
    bits = {32'h00FF_0000, 64'hFFFF_FFFF_FFFF_FFFF};
    load_cfg(bits, NBEATS, 1'b1);
    infer("win2", 8'hFF, 4'b0100, 2'd2);
    bits = {32'hFF00_FF00, 64'hFFFF_FFFF_FFFF_FFFF};
    load_cfg(bits, NBEATS, 1'b1);
    infer("tie13", 8'hFF, 4'b1010, 2'd1);

    // Back-to-back samples followed by a load request
    @(posedge clk) #1; in_valid = 1'b1; in_data = 8'($urandom);
    @(posedge clk) #1; in_data = 8'($urandom);
    @(posedge clk) #1; in_valid = 1'b0; load_start = 1'b1;
    @(posedge clk) #1; load_start = 1'b0;
    @(negedge clk); chk("drain_lr0", 32'(load_ready), 32'd0);
    @(negedge clk); chk("drain_lr1", 32'(load_ready), 32'd0);
    @(negedge clk); chk("drain_lr2", 32'(load_ready), 32'd1);
    bits = {$urandom, $urandom, $urandom};
    load_cfg(bits, NBEATS, 1'b0);

    // Partial load abandoned by reset
    load_cfg({$urandom, $urandom, $urandom}, 10, 1'b1);
    do_reset();
    @(negedge clk);
    chk("abort_cfg", 32'(cfg_loaded), 32'd0);
    @(posedge clk) #1; load_valid = 1'b1; load_data = 4'hF;
    repeat (5) @(posedge clk);
    #1 load_valid = 1'b0;
    infer("run_beats_ignored", 8'hFF, 4'hF, 2'd0);

    // Enable freeze with a sample in flight
    @(posedge clk) #1; in_valid = 1'b1; in_data = 8'hFF;
    @(posedge clk) #1; in_valid = 1'b0; ena = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); chk("frz_valid", 32'(out_valid), 32'd0);
    @(posedge clk) #1; ena = 1'b1;
    @(negedge clk); chk("frz_mid", 32'(out_valid), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("frz_out_valid", 32'(out_valid), 32'd1);
    chk("frz_out_data", 32'(out_data), 32'hF);

    // Full load after abort needs all beats
    bits = '1;
    load_cfg(bits, NBEATS, 1'b1);
    @(negedge clk); chk("reload_cfg", 32'(cfg_loaded), 32'd1);
    infer("reload_x0F", 8'h0F, 4'hF, 2'd0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk) #1;
      ena        = ($urandom_range(0, 3) != 0);
      in_valid   = $urandom_range(0, 1);
      in_data    = 8'($urandom);
      load_start = ($urandom_range(0, 60) == 0);
      load_valid = $urandom_range(0, 1);
      load_data  = 4'($urandom);
    end
    @(posedge clk) #1;
    ena = 1'b1; in_valid = 1'b0; load_start = 1'b0; load_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
